// File: rtl/i2c_fifo_pkg.sv
// Shared constants, types and helpers for the I2C byte FIFO slice.
package i2c_fifo_pkg;

  localparam int unsigned I2C_FIFO_DATA_W = 8;
  localparam int unsigned I2C_FIFO_DEPTH  = 16;

  // Byte word carried on the I2C TX/RX paths.
  typedef logic [I2C_FIFO_DATA_W-1:0] i2c_byte_t;

  // Per-cycle accepted operation, encoded as {rd_acc, wr_acc}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_WR   = 2'b01,
    OP_RD   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Occupancy counter width: one extra bit so that DEPTH itself is representable.
  function automatic int unsigned fifo_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/i2c_fifo_mem.sv
// Simple dual-port storage array: one synchronous write port, one
// synchronous read port. The array itself is never reset; only the
// read-data register is cleared.
module i2c_fifo_mem
  import i2c_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = I2C_FIFO_DATA_W,
  parameter int unsigned DEPTH  = I2C_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store incoming word at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: register the addressed word; hold the last value when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/i2c_sync_fifo.sv
// Parametrised synchronous byte FIFO between the I2C bit engine and the
// host/register side. Independent read/write enables, exact DEPTH capacity,
// watermarks, occupancy count and a registered read-valid strobe.
// Optional sticky overflow/underflow flags with err_clr: I2C_FIFO_ERR_EN.
module i2c_sync_fifo
  import i2c_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = I2C_FIFO_DATA_W,
  parameter int unsigned DEPTH      = I2C_FIFO_DEPTH,
  parameter int unsigned AFULL_THR  = DEPTH - 2,
  parameter int unsigned AEMPTY_THR = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            din,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            dout,
  output logic                         dout_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [fifo_cnt_w(DEPTH)-1:0] count
`ifdef I2C_FIFO_ERR_EN
  ,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = fifo_cnt_w(DEPTH);

  localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THR);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THR);

  logic [AW-1:0] wrptr;
  logic [AW-1:0] rdptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          wr_acc;
  logic          rd_acc;
  fifo_op_e      op;

  // Flags decode the registered count only, never same-cycle inputs.
  assign full         = (cnt == FULL_C);
  assign empty        = (cnt == '0);
  assign almost_full  = (cnt >= AFULL_C);
  assign almost_empty = (cnt <= AEMPTY_C);
  assign count        = cnt;

  // Full blocks writes even when a read frees space this cycle; empty blocks
  // reads even when a write lands this cycle (no fall-through).
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Classify the accepted operation and derive the next occupancy.
  always_comb begin
    op      = fifo_op_e'({rd_acc, wr_acc});
    cnt_nxt = cnt;
    case (op)
      OP_WR:   cnt_nxt = cnt + CW'(1);
      OP_RD:   cnt_nxt = cnt - CW'(1);
      default: cnt_nxt = cnt;
    endcase
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Write pointer: advances on each accepted write, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrptr <= '0;
    end else if (wr_acc) begin
      wrptr <= wrptr + AW'(1);
    end
  end

  // Read pointer: advances on each accepted read, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdptr <= '0;
    end else if (rd_acc) begin
      rdptr <= rdptr + AW'(1);
    end
  end

  // Read-valid strobe: one pulse per accepted read, aligned with dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
    end
  end

  i2c_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wrptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rdptr),
    .rdata (dout)
  );

`ifdef I2C_FIFO_ERR_EN
  // Sticky overflow: a set condition wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end else if (err_clr) begin
      overflow <= 1'b0;
    end
  end

  // Sticky underflow: a set condition wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (rd_en && empty) begin
      underflow <= 1'b1;
    end else if (err_clr) begin
      underflow <= 1'b0;
    end
  end
`else
  // Without error tracking, rejected requests are dropped silently.
`endif

endmodule

// File: tb/tb_i2c_sync_fifo.sv
// Directed self-checking bench for i2c_sync_fifo (DEPTH=16, DATA_W=8).
module tb_i2c_sync_fifo;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] din;
  logic       rd_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
`ifdef I2C_FIFO_ERR_EN
  logic       err_clr;
  logic       overflow;
  logic       underflow;
`endif

  int errors = 0;
  int checks = 0;

  i2c_sync_fifo #(
    .DATA_W     (8),
    .DEPTH      (16),
    .AFULL_THR  (14),
    .AEMPTY_THR (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count)
`ifdef I2C_FIFO_ERR_EN
    ,
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of requests, then sample 1 time unit after the edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd);
    wr_en = wr;
    din   = d;
    rd_en = rd;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  int         mq[$];
  int         exp_d;
  logic [7:0] wd;
  logic       dw;
  logic       dr;

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
`ifdef I2C_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    reset = 1'b0;
    step(0, 8'h00, 0);

    // Reset / idle state
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_aempty", 32'(almost_empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_afull", 32'(almost_full), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_dvalid", 32'(dout_valid), 0);
`ifdef I2C_FIFO_ERR_EN
    check("rst_ovf", 32'(overflow), 0);
    check("rst_udf", 32'(underflow), 0);
`endif

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0);
      check("fill_count", 32'(count), 32'(i));
      check("fill_full", 32'(full), (i == 16) ? 1 : 0);
      check("fill_afull", 32'(almost_full), (i >= 14) ? 1 : 0);
      check("fill_aempty", 32'(almost_empty), (i <= 2) ? 1 : 0);
      check("fill_empty", 32'(empty), 0);
    end

    // 17th write is dropped
    step(1, 8'hAA, 0);
    check("ovf_count", 32'(count), 16);
    check("ovf_full", 32'(full), 1);
`ifdef I2C_FIFO_ERR_EN
    check("ovf_flag", 32'(overflow), 1);
`endif

    // Drain: 0x01..0x10, dout_valid every popped cycle
    for (int i = 1; i <= 16; i++) begin
      step(0, 8'h00, 1);
      check("drain_dout", 32'(dout), 32'(i));
      check("drain_dvalid", 32'(dout_valid), 1);
      check("drain_count", 32'(count), 32'(16 - i));
    end
    check("drain_empty", 32'(empty), 1);

    // Read while empty: rejected, dout holds
    step(0, 8'h00, 1);
    check("udf_dout", 32'(dout), 32'h10);
    check("udf_dvalid", 32'(dout_valid), 0);
    check("udf_count", 32'(count), 0);
`ifdef I2C_FIFO_ERR_EN
    check("udf_flag", 32'(underflow), 1);
    check("udf_ovf_sticky", 32'(overflow), 1);
    err_clr = 1'b1;
    step(0, 8'h00, 0);
    err_clr = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_udf", 32'(underflow), 0);
`endif

    // Simultaneous read+write at count=5
    for (int i = 0; i < 5; i++) step(1, 8'(8'h21 + i), 0);
    check("c5_count", 32'(count), 5);
    step(1, 8'h26, 1);
    check("c5_both_count", 32'(count), 5);
    check("c5_both_dout", 32'(dout), 32'h21);
    check("c5_both_dvalid", 32'(dout_valid), 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 8'h00, 1);
      check("c5_order", 32'(dout), 32'(8'h22 + i));
    end
    check("c5_empty", 32'(empty), 1);

    // Simultaneous read+write at full: write rejected
    for (int i = 0; i < 16; i++) step(1, 8'(8'h30 + i), 0);
    check("f_full", 32'(full), 1);
    step(1, 8'hEE, 1);
    check("f_both_count", 32'(count), 15);
    check("f_both_dout", 32'(dout), 32'h30);
    check("f_both_full", 32'(full), 0);
    for (int i = 1; i < 16; i++) begin
      step(0, 8'h00, 1);
      check("f_drain", 32'(dout), 32'(8'h30 + i));
    end
    check("f_drain_empty", 32'(empty), 1);

    // Simultaneous read+write at empty: read rejected, no fall-through
    step(1, 8'h77, 1);
    check("e_both_count", 32'(count), 1);
    check("e_both_dvalid", 32'(dout_valid), 0);
    check("e_both_dout", 32'(dout), 32'h3F);
    step(0, 8'h00, 1);
    check("e_read_dout", 32'(dout), 32'h77);
    check("e_read_dvalid", 32'(dout_valid), 1);
`ifdef I2C_FIFO_ERR_EN
    err_clr = 1'b1;
    step(0, 8'h00, 0);
    err_clr = 1'b0;
`endif

    // Wrap-around: interleaved traffic keeping occupancy in 3..10
    for (int i = 0; i < 3; i++) begin
      wd = 8'(8'hC0 + i);
      mq.push_back(int'(wd));
      step(1, wd, 0);
    end
    for (int k = 0; k < 40; k++) begin
      wd = 8'(k * 7 + 3);
      if (mq.size() >= 10) begin
        dw = 1'b0; dr = 1'b1;
      end else if (mq.size() <= 3) begin
        dw = 1'b1; dr = 1'b0;
      end else begin
        dw = (k % 3) != 1;
        dr = (k % 3) != 0;
      end
      exp_d = 0;
      if (dr) exp_d = mq.pop_front();
      if (dw) mq.push_back(int'(wd));
      step(dw, wd, dr);
      if (dr) check("wrap_dout", 32'(dout), 32'(exp_d));
      check("wrap_dvalid", 32'(dout_valid), 32'(dr));
      check("wrap_count", 32'(count), 32'(mq.size()));
    end
    while (mq.size() > 0) begin
      exp_d = mq.pop_front();
      step(0, 8'h00, 1);
      check("wrap_tail", 32'(dout), 32'(exp_d));
    end
    check("wrap_empty", 32'(empty), 1);

    // Reset mid-stream at count=7
    for (int i = 0; i < 7; i++) step(1, 8'(8'h90 + i), 0);
    check("mid_count", 32'(count), 7);
    reset = 1'b1;
    step(0, 8'h00, 1);
    reset = 1'b0;
    check("mrst_count", 32'(count), 0);
    check("mrst_empty", 32'(empty), 1);
    check("mrst_dvalid", 32'(dout_valid), 0);
    check("mrst_dout", 32'(dout), 0);
    step(0, 8'h00, 1);
    check("mrst_next_dvalid", 32'(dout_valid), 0);
    check("mrst_next_count", 32'(count), 0);
    step(1, 8'h55, 0);
    step(1, 8'h66, 0);
    check("post_count", 32'(count), 2);
    step(0, 8'h00, 1);
    check("post_rd0", 32'(dout), 32'h55);
    step(0, 8'h00, 1);
    check("post_rd1", 32'(dout), 32'h66);
    check("post_empty", 32'(empty), 1);

`ifdef I2C_FIFO_ERR_EN
    // Overflow set, set-wins-over-clear, then clear
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    step(1, 8'hAA, 0);
    check("err_ovf_set", 32'(overflow), 1);
    err_clr = 1'b1;
    step(1, 8'hAB, 0);
    check("err_set_wins", 32'(overflow), 1);
    step(0, 8'h00, 0);
    err_clr = 1'b0;
    check("err_ovf_clr", 32'(overflow), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
